pipe_stage_reg: RTL and testbench

//  Parametrised pipeline register for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: a data payload plus a control bundle behind a valid/ready handshake, with synchronous flush.
// Build option PIPE_STAGE_SKID_EN adds a second (skid) entry so that in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int DATA_W = 141,
  parameter int CTRL_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              accept;
  logic              drain;

  assign accept = in_valid & in_ready;
  assign drain  = m_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

  // Ready depends only on the skid flop, so there is no path from out_ready to in_ready.
  assign in_ready  = ~s_valid_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      if (drain) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = accept;
        if (accept) begin
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end
      end
    end else if (accept) begin
      if (m_valid_q && !drain) begin
        // M is stalled downstream, so the new entry parks in S.
        s_valid_d = 1'b1;
        s_data_d  = in_data;
        s_ctrl_d  = in_ctrl;
      end else begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end
    end else if (drain) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end
`else
  assign in_ready  = ~m_valid_q | out_ready;
  assign occupancy = {1'b0, m_valid_q};

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
    end else if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = in_data;
      m_ctrl_d  = in_ctrl;
    end else if (drain) begin
      m_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
    end
  end

  // Control is forced to zero whenever no valid entry is presented, making a bubble harmless.
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, flush, accept+drain, async reset.
// Works in both builds; define PIPE_STAGE_SKID_EN for the skid build.
module tb_pipe_stage_reg;
  localparam int DATA_W = 141;
  localparam int CTRL_W = 7;
`ifdef PIPE_STAGE_SKID_EN
  localparam int MAX_OCC = 2;
`else
  localparam int MAX_OCC = 1;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int n_drained = 0;
  logic [CTRL_W+DATA_W-1:0] exp_q[$];
  logic [CTRL_W+DATA_W-1:0] head;
  logic [1:0] exp_occ;
  logic       exp_rdy;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int v);
    logic [31:0] w;
    w = v;
    return {w[20:0], 88'h0, w};
  endfunction

  // One clock: inputs already driven; settle, check against the scoreboard, clock, step past the edge.
  task automatic cycle();
    #1;
    exp_occ = 2'(exp_q.size());
    exp_rdy = (MAX_OCC == 2) ? (exp_q.size() < 2) : ((exp_q.size() == 0) || out_ready);
    check("occ", occupancy, exp_occ);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() == 0) begin
      check("ctrl_bubble", out_ctrl, 0);
    end else begin
      head = exp_q[0];
      check("out_ctrl", out_ctrl, head[CTRL_W+DATA_W-1:DATA_W]);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("drain_empty", 1, 0);
      end else begin
        head = exp_q.pop_front();
        check("out_data", out_data, head[DATA_W-1:0]);
        n_drained++;
        $display("xfer data=%0h ctrl=%0h", out_data, out_ctrl);
      end
    end
    if (flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; in_data = mk(99); in_ctrl = 7'h7F;
    flush = 1'b0; out_ready = 1'b0;

    // 1: reset holds everything at zero even with in_valid high; first entry visible one clock after release
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_occ", occupancy, 0);
    check("rst_data", out_data, 0);
    reset_n = 1'b1;
    in_data = mk(1); in_ctrl = 7'h2A;
    #1;
    check("rst_rdy", in_ready, 1);
    @(posedge clock);
    #1;
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, mk(1));
    check("lat_ctrl", out_ctrl, 7'h2A);
    exp_q.push_back({7'h2A, mk(1)});
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // 2: streaming 0..15
    in_ctrl = 7'h55;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = mk(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    check("stream_cnt", 32'(n_drained), 17);

    // 3: backpressure, out_ready low for three cycles in the middle of the stream
    n_drained = 0;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 30; c++) begin
        out_ready = !(c >= 2 && c <= 4);
        in_valid  = (sent < 8);
        in_data   = mk(100 + sent); in_ctrl = 7'(sent + 1);
        #1;
        if (in_valid && in_ready) sent++;
        cycle();
        if (c == 4) begin
          check("bp_occ", occupancy, MAX_OCC);
          check("bp_rdy", in_ready, 0);
        end
      end
    end
    check("bp_cnt", 32'(n_drained), 8);

    // 4: flush with stalled entries and a new entry offered in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 7'h11;
    in_data = mk(200); cycle();
    in_data = mk(201); cycle();
    check("fl_pre_occ", occupancy, MAX_OCC);
    flush = 1'b1; in_data = mk(202); cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_occ", occupancy, 0);
    out_ready = 1'b1;
    repeat (3) cycle();

    // flush while draining: the head entry is still consumed
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(300); cycle();
    in_data = mk(301); cycle();
    n_drained = 0;
    out_ready = 1'b1; flush = 1'b1; in_data = mk(302); cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("fd_cnt", 32'(n_drained), 1);
    check("fd_occ", occupancy, 0);

    // 5: accept+drain every cycle keeps occupancy at 1 and in_ready high
    in_valid = 1'b1; in_data = mk(400); in_ctrl = 7'h33;
    cycle();
    for (int i = 1; i < 8; i++) begin
      in_data = mk(400 + i);
      cycle();
      check("ad_occ", occupancy, 1);
      check("ad_rdy", in_ready, 1);
    end
    in_valid = 1'b0;
    cycle();

    // 6: asynchronous reset between edges with the stage full
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 7'h44;
    in_data = mk(500); cycle();
    in_data = mk(501); cycle();
    check("ar_pre_occ", occupancy, MAX_OCC);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ctrl", out_ctrl, 0);
    check("ar_data", out_data, 0);
    check("ar_occ", occupancy, 0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
